// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: controller state encodings and width limit.
package serial_subtractor_ctrl_pkg;

  localparam int SERSUB_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    SS_IDLE  = 2'd0,
    SS_SHIFT = 2'd1,
    SS_DONE  = 2'd2
  } ss_state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_fullsubtractor_sf.sv
// Single-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module fullsubtractor_sf (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit unsigned subtractor, LSB first, one bit per clock through one cell.
// Build option: define SERSUB_SAT_EN to clamp diff to 0 when the result borrows.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ss_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_shift;
  logic             cell_d, cell_bout;

`ifdef SERSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_unsigned(input logic [WIDTH-1:0] raw,
                                                    input logic             neg);
    return neg ? '0 : raw;
  endfunction
`endif

  fullsubtractor_sf u_cell (
    .d    (cell_d),
    .bout (cell_bout),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    diff_d    = diff_q;
    cnt_d     = cnt_q;
    brw_d     = brw_q;
    borrow_d  = borrow_q;
    res_shift = res_q >> 1;
    res_shift[WIDTH-1] = cell_d;

    case (state_q)
      SS_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_shift;
        brw_d  = cell_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = SS_DONE;
          borrow_d = cell_bout;
`ifdef SERSUB_SAT_EN
          diff_d   = sat_unsigned(res_shift, cell_bout);
`else
          diff_d   = res_shift;
`endif
        end
      end
      SS_IDLE, SS_DONE: begin
        // DONE accepts a new start directly so back-to-back ops skip IDLE
        if (start) begin
          state_d = SS_SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          brw_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = SS_IDLE;
        end
      end
      default: state_d = SS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SS_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == SS_SHIFT);
  assign done   = (state_q == SS_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule
